// File: rtl/pin_pkg.sv
// pin_pkg: key codes, empty-slot value and the FSM state
// enum shared by the PIN entry buffer and its timer.
package pin_pkg;

   localparam logic [3:0] KEY_BACK    = 4'hA;
   localparam logic [3:0] KEY_CLEAR   = 4'hB;
   localparam logic [3:0] KEY_ENTER   = 4'hF;
   localparam logic [3:0] EMPTY_DIGIT = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_SUBMIT,
      ST_FLUSH
   } pin_state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

endpackage

// File: rtl/pin_timer.sv
// pin_timer: loadable down-counter. Ports: clk, rst (async low),
// load/load_value (reload), expired (high while count is 1).
module pin_timer
   import pin_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_value;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   // Count of 1 means the next edge completes the interval.
   assign expired = (cnt == W'(1));

endmodule

// File: rtl/pin_entry_buffer.sv
// pin_entry_buffer: keypad PIN accumulator. Inputs clk, rst, key_valid,
// key_code; outputs pin_digits, pin_count, pin_status, pin_timeout, key_reject.
module pin_entry_buffer
   import pin_pkg::*;
#(
   parameter int PIN_LEN        = 4,
   parameter int STATUS_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 0,
   parameter bit SHIFT_ON_FULL  = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         key_valid,
   input  logic [3:0]                   key_code,
   output logic [PIN_LEN*4-1:0]         pin_digits,
   output logic [$clog2(PIN_LEN+1)-1:0] pin_count,
   output logic                         pin_status,
   output logic                         pin_timeout,
   output logic                         key_reject
);

   localparam int DW = PIN_LEN * 4;
   localparam int CW = $clog2(PIN_LEN + 1);
   localparam int SW = $clog2(STATUS_CYCLES + 1);
   localparam logic [DW-1:0] ALL_EMPTY = {PIN_LEN{EMPTY_DIGIT}};

   pin_state_t    state;
   pin_state_t    nx_state;
   logic [DW-1:0] nx_digits;
   logic [CW-1:0] nx_count;
   logic          nx_reject;
   logic          nx_timeout;
   logic [DW-1:0] sh;
   logic [DW-1:0] bk;
   logic          full;
   logic          st_load;
   logic          st_expired;
   logic          tmo_expired;

   pin_timer #(.W(SW)) u_status (
      .clk        (clk),
      .rst        (rst),
      .load       (st_load),
      .load_value (SW'(STATUS_CYCLES)),
      .expired    (st_expired)
   );

   // Any key, accepted or not, restarts the idle interval.
   if (TIMEOUT_CYCLES > 0) begin : g_tmo
      localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
      pin_timer #(.W(TW)) u_timeout (
         .clk        (clk),
         .rst        (rst),
         .load       (key_valid),
         .load_value (TW'(TIMEOUT_CYCLES)),
         .expired    (tmo_expired)
      );
   end else begin : g_no_tmo
      assign tmo_expired = 1'b0;
   end

   always_comb begin
      nx_state   = state;
      nx_digits  = pin_digits;
      nx_count   = pin_count;
      nx_reject  = 1'b0;
      nx_timeout = 1'b0;
      st_load    = 1'b0;
      // New digit enters slot 0, everything moves toward the oldest slot.
      sh         = pin_digits << 4;
      sh[3:0]    = key_code;
      // Backspace drops slot 0 and refills the oldest slot.
      bk         = pin_digits >> 4;
      bk[DW-1 -: 4] = EMPTY_DIGIT;
      full       = (pin_count == CW'(PIN_LEN));

      unique case (state)
         ST_IDLE: begin
            if (key_valid) begin
               if (is_digit(key_code)) begin
                  nx_digits = sh;
                  nx_count  = CW'(1);
                  nx_state  = ST_ENTRY;
               end else begin
                  nx_reject = 1'b1;
               end
            end
         end
         ST_ENTRY: begin
            if (key_valid) begin
               unique case (1'b1)
                  is_digit(key_code): begin
                     if (!full) begin
                        nx_digits = sh;
                        nx_count  = pin_count + CW'(1);
                     end else if (SHIFT_ON_FULL) begin
                        nx_digits = sh;
                     end else begin
                        nx_reject = 1'b1;
                     end
                  end
                  (key_code == KEY_BACK): begin
                     nx_digits = bk;
                     nx_count  = pin_count - CW'(1);
                     if (pin_count == CW'(1)) begin
                        nx_state = ST_IDLE;
                     end
                  end
                  (key_code == KEY_CLEAR): begin
                     nx_digits = ALL_EMPTY;
                     nx_count  = '0;
                     nx_state  = ST_IDLE;
                  end
                  (key_code == KEY_ENTER): begin
                     nx_state = ST_SUBMIT;
                     st_load  = 1'b1;
                  end
                  default: begin
                     nx_reject = 1'b1;
                  end
               endcase
            end else if (tmo_expired) begin
               nx_digits  = ALL_EMPTY;
               nx_count   = '0;
               nx_timeout = 1'b1;
               nx_state   = ST_IDLE;
            end
         end
         ST_SUBMIT: begin
            nx_reject = key_valid;
            if (st_expired) begin
               nx_state = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            nx_reject = key_valid;
            nx_digits = ALL_EMPTY;
            nx_count  = '0;
            nx_state  = ST_IDLE;
         end
         default: begin
            nx_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         pin_digits  <= ALL_EMPTY;
         pin_count   <= '0;
         pin_status  <= 1'b0;
         pin_timeout <= 1'b0;
         key_reject  <= 1'b0;
      end else begin
         state       <= nx_state;
         pin_digits  <= nx_digits;
         pin_count   <= nx_count;
         pin_status  <= (nx_state == ST_SUBMIT);
         pin_timeout <= nx_timeout;
         key_reject  <= nx_reject;
      end
   end

endmodule

// File: tb/tb_pin_entry_buffer.sv
// tb_pin_entry_buffer: vector table plus scoreboard for two
// buffer configurations (defaults; no-shift with timeout 10).
module tb_pin_entry_buffer;

   localparam logic [3:0] K_BK = 4'hA;
   localparam logic [3:0] K_CL = 4'hB;
   localparam logic [3:0] K_EN = 4'hF;

   typedef struct {
      string       nm;
      bit          rs;
      bit          sel;
      logic        kv;
      logic [3:0]  kc;
      logic [15:0] dig;
      logic [2:0]  cnt;
      logic        st;
      logic        to;
      logic        rj;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        kv = 1'b0;
   logic [3:0]  kc = 4'h0;
   logic [15:0] a_dig, b_dig;
   logic [2:0]  a_cnt, b_cnt;
   logic        a_st, a_to, a_rj;
   logic        b_st, b_to, b_rj;

   int nvec = 0;
   int nerr = 0;
   vec_t tbl[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   pin_entry_buffer u_a (
      .clk(clk), .rst(rst),
      .key_valid(kv), .key_code(kc),
      .pin_digits(a_dig), .pin_count(a_cnt),
      .pin_status(a_st), .pin_timeout(a_to),
      .key_reject(a_rj)
   );

   pin_entry_buffer #(
      .TIMEOUT_CYCLES(10), .SHIFT_ON_FULL(1'b0)
   ) u_b (
      .clk(clk), .rst(rst),
      .key_valid(kv), .key_code(kc),
      .pin_digits(b_dig), .pin_count(b_cnt),
      .pin_status(b_st), .pin_timeout(b_to),
      .key_reject(b_rj)
   );

   function automatic vec_t mk(
      string nm, bit rs, bit sel, logic v, logic [3:0] c,
      logic [15:0] d, logic [2:0] n, logic s, logic t, logic r);
      vec_t x;
      x.nm = nm; x.rs = rs; x.sel = sel; x.kv = v; x.kc = c;
      x.dig = d; x.cnt = n; x.st = s; x.to = t; x.rj = r;
      return x;
   endfunction

   task automatic check(input vec_t e);
      logic [15:0] d;
      logic [2:0]  n;
      logic        s, t, r;
      d = e.sel ? b_dig : a_dig;
      n = e.sel ? b_cnt : a_cnt;
      s = e.sel ? b_st : a_st;
      t = e.sel ? b_to : a_to;
      r = e.sel ? b_rj : a_rj;
      nvec++;
      if (d !== e.dig || n !== e.cnt || s !== e.st ||
          t !== e.to || r !== e.rj) begin
         nerr++;
         $display("FAIL %s: got dig=%h cnt=%0d st=%b to=%b rj=%b want dig=%h cnt=%0d st=%b to=%b rj=%b",
                  e.nm, d, n, s, t, r, e.dig, e.cnt, e.st, e.to, e.rj);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      kv  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic apply(input vec_t v);
      vec_t e;
      if (v.rs) do_reset();
      @(negedge clk);
      kv = v.kv;
      kc = v.kc;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(e);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      // Defaults: 1,2,3,4,ENTER and flush.
      tbl.push_back(mk("def_k1",  1,0,1,4'h1,16'hFFF1,1,0,0,0));
      tbl.push_back(mk("def_k2",  0,0,1,4'h2,16'hFF12,2,0,0,0));
      tbl.push_back(mk("def_k3",  0,0,1,4'h3,16'hF123,3,0,0,0));
      tbl.push_back(mk("def_k4",  0,0,1,4'h4,16'h1234,4,0,0,0));
      tbl.push_back(mk("def_ent", 0,0,1,K_EN,16'h1234,4,1,0,0));
      tbl.push_back(mk("def_s2",  0,0,0,4'h0,16'h1234,4,1,0,0));
      tbl.push_back(mk("def_fl",  0,0,0,4'h0,16'h1234,4,0,0,0));
      tbl.push_back(mk("def_idl", 0,0,0,4'h0,16'hFFFF,0,0,0,0));
      // Overflow, shifting instance.
      tbl.push_back(mk("ovA_k1",  1,0,1,4'h1,16'hFFF1,1,0,0,0));
      tbl.push_back(mk("ovA_k2",  0,0,1,4'h2,16'hFF12,2,0,0,0));
      tbl.push_back(mk("ovA_k3",  0,0,1,4'h3,16'hF123,3,0,0,0));
      tbl.push_back(mk("ovA_k4",  0,0,1,4'h4,16'h1234,4,0,0,0));
      tbl.push_back(mk("ovA_k5",  0,0,1,4'h5,16'h2345,4,0,0,0));
      // Overflow, rejecting instance.
      tbl.push_back(mk("ovB_k1",  1,1,1,4'h1,16'hFFF1,1,0,0,0));
      tbl.push_back(mk("ovB_k2",  0,1,1,4'h2,16'hFF12,2,0,0,0));
      tbl.push_back(mk("ovB_k3",  0,1,1,4'h3,16'hF123,3,0,0,0));
      tbl.push_back(mk("ovB_k4",  0,1,1,4'h4,16'h1234,4,0,0,0));
      tbl.push_back(mk("ovB_k5",  0,1,1,4'h5,16'h1234,4,0,0,1));
      tbl.push_back(mk("ovB_idl", 0,1,0,4'h0,16'h1234,4,0,0,0));
      tbl.push_back(mk("ovB_clr", 0,1,1,K_CL,16'hFFFF,0,0,0,0));
      // Editing with backspace.
      tbl.push_back(mk("ed_k7",   1,0,1,4'h7,16'hFFF7,1,0,0,0));
      tbl.push_back(mk("ed_k8",   0,0,1,4'h8,16'hFF78,2,0,0,0));
      tbl.push_back(mk("ed_bk",   0,0,1,K_BK,16'hFFF7,1,0,0,0));
      tbl.push_back(mk("ed_k9",   0,0,1,4'h9,16'hFF79,2,0,0,0));
      tbl.push_back(mk("ed_ent",  0,0,1,K_EN,16'hFF79,2,1,0,0));
      tbl.push_back(mk("ed_s2",   0,0,0,4'h0,16'hFF79,2,1,0,0));
      tbl.push_back(mk("ed_fl",   0,0,0,4'h0,16'hFF79,2,0,0,0));
      tbl.push_back(mk("ed_idl",  0,0,0,4'h0,16'hFFFF,0,0,0,0));
      tbl.push_back(mk("cl_k7",   0,0,1,4'h7,16'hFFF7,1,0,0,0));
      tbl.push_back(mk("cl_k8",   0,0,1,4'h8,16'hFF78,2,0,0,0));
      tbl.push_back(mk("cl_clr",  0,0,1,K_CL,16'hFFFF,0,0,0,0));
      tbl.push_back(mk("cl_bkid", 0,0,1,K_BK,16'hFFFF,0,0,0,1));
      // Rejects in IDLE, ENTRY, SUBMIT and FLUSH.
      tbl.push_back(mk("rj_entid",1,0,1,K_EN,16'hFFFF,0,0,0,1));
      tbl.push_back(mk("rj_idl",  0,0,0,4'h0,16'hFFFF,0,0,0,0));
      tbl.push_back(mk("rj_k3",   0,0,1,4'h3,16'hFFF3,1,0,0,0));
      tbl.push_back(mk("rj_kc",   0,0,1,4'hC,16'hFFF3,1,0,0,1));
      tbl.push_back(mk("rj_k4",   0,0,1,4'h4,16'hFF34,2,0,0,0));
      tbl.push_back(mk("rj_ent",  0,0,1,K_EN,16'hFF34,2,1,0,0));
      tbl.push_back(mk("rj_sub",  0,0,1,4'h5,16'hFF34,2,1,0,1));
      tbl.push_back(mk("rj_fl",   0,0,0,4'h0,16'hFF34,2,0,0,0));
      tbl.push_back(mk("rj_flk",  0,0,1,4'h6,16'hFFFF,0,0,0,1));
      tbl.push_back(mk("rj_first",0,0,1,4'h7,16'hFFF7,1,0,0,0));
      // Timeout fires after 10 idle cycles.
      tbl.push_back(mk("to_k5",   1,1,1,4'h5,16'hFFF5,1,0,0,0));
      for (int i = 1; i <= 9; i++)
         tbl.push_back(mk($sformatf("to_w%0d", i),
                          0,1,0,4'h0,16'hFFF5,1,0,0,0));
      tbl.push_back(mk("to_fire", 0,1,0,4'h0,16'hFFFF,0,0,1,0));
      tbl.push_back(mk("to_after",0,1,0,4'h0,16'hFFFF,0,0,0,0));
      // Key at cycle 9 restarts the interval.
      tbl.push_back(mk("tr_k5",   1,1,1,4'h5,16'hFFF5,1,0,0,0));
      for (int i = 1; i <= 8; i++)
         tbl.push_back(mk($sformatf("tr_w%0d", i),
                          0,1,0,4'h0,16'hFFF5,1,0,0,0));
      tbl.push_back(mk("tr_k6",   0,1,1,4'h6,16'hFF56,2,0,0,0));
      for (int i = 10; i <= 12; i++)
         tbl.push_back(mk($sformatf("tr_w%0d", i),
                          0,1,0,4'h0,16'hFF56,2,0,0,0));
      // Key in the expiry cycle wins over the timeout.
      tbl.push_back(mk("te_k5",   1,1,1,4'h5,16'hFFF5,1,0,0,0));
      for (int i = 1; i <= 9; i++)
         tbl.push_back(mk($sformatf("te_w%0d", i),
                          0,1,0,4'h0,16'hFFF5,1,0,0,0));
      tbl.push_back(mk("te_k7",   0,1,1,4'h7,16'hFF57,2,0,0,0));
      tbl.push_back(mk("te_idl",  0,1,0,4'h0,16'hFF57,2,0,0,0));

      // Reset state while rst is held low.
      #12;
      check(mk("rst_a",0,0,0,4'h0,16'hFFFF,0,0,0,0));
      check(mk("rst_b",0,1,0,4'h0,16'hFFFF,0,0,0,0));
      rst = 1'b1;

      foreach (tbl[i]) apply(tbl[i]);

      // Asynchronous reset in the middle of SUBMIT.
      apply(mk("ar_k1",  1,0,1,4'h1,16'hFFF1,1,0,0,0));
      apply(mk("ar_k2",  0,0,1,4'h2,16'hFF12,2,0,0,0));
      apply(mk("ar_ent", 0,0,1,K_EN,16'hFF12,2,1,0,0));
      kv = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check(mk("ar_async",0,0,0,4'h0,16'hFFFF,0,0,0,0));
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++)
         apply(mk($sformatf("ar_post%0d", i),
                  0,0,0,4'h0,16'hFFFF,0,0,0,0));

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
